// File: rtl/adder_pipe.sv
// Pipelined ripple-carry adder: one SEG-bit segment per stage, carry registered between stages.
// Latency NSEG clocks, one add per clock; whole pipe stalls on out_valid & ~out_ready. Macro ADD_SUB_EN adds a subtract port.
module adder_pipe #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NSEG = WIDTH / SEG;

   logic             adv;
   logic [WIDTH-1:0] b_x;
   logic             c_x;

   assign adv      = out_ready | ~out_valid;
   assign in_ready = adv;

   // Subtract is folded in at entry as a + ~b + 1, so later stages only ever add.
`ifdef ADD_SUB_EN
   assign b_x = sub ? ~b : b;
   assign c_x = sub ? 1'b1 : cin;
`else
   assign b_x = b;
   assign c_x = cin;
`endif

   for (genvar k = 0; k < NSEG; k++) begin : stg
      localparam int RW = WIDTH - k * SEG;

      logic [RW-1:0]        a_i;
      logic [RW-1:0]        b_i;
      logic                 c_i;
      logic                 v_i;
      logic [SEG:0]         r;
      logic [(k+1)*SEG-1:0] s_nxt;
      logic [(k+1)*SEG-1:0] sum_q;
      logic                 cy_q;
      logic                 vld_q;

      if (k == 0) begin : head
         assign a_i   = a;
         assign b_i   = b_x;
         assign c_i   = c_x;
         assign v_i   = in_valid;
         assign s_nxt = r[SEG-1:0];
      end else begin : body
         assign a_i   = stg[k-1].fwd.ra_q;
         assign b_i   = stg[k-1].fwd.rb_q;
         assign c_i   = stg[k-1].cy_q;
         assign v_i   = stg[k-1].vld_q;
         assign s_nxt = {r[SEG-1:0], stg[k-1].sum_q};
      end

      assign r = {1'b0, a_i[SEG-1:0]} + {1'b0, b_i[SEG-1:0]} + {{SEG{1'b0}}, c_i};

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            cy_q  <= 1'b0;
            sum_q <= '0;
         end else if (adv) begin
            vld_q <= v_i;
            cy_q  <= r[SEG];
            sum_q <= s_nxt;
         end
      end

      // Operand skew: bits not yet added travel alongside toward their stage.
      if (k < NSEG - 1) begin : fwd
         logic [RW-SEG-1:0] ra_q;
         logic [RW-SEG-1:0] rb_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ra_q <= '0;
               rb_q <= '0;
            end else if (adv) begin
               ra_q <= a_i[RW-1:SEG];
               rb_q <= b_i[RW-1:SEG];
            end
         end
      end

      if (k == NSEG - 1) begin : last
         logic msb_cin;
         logic ovf_q;

         assign msb_cin = a_i[SEG-1] ^ b_i[SEG-1] ^ r[SEG-1];

         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               ovf_q <= 1'b0;
            else if (adv)
               ovf_q <= msb_cin ^ r[SEG];
         end
      end
   end

   assign out_valid = stg[NSEG-1].vld_q;
   assign sum       = stg[NSEG-1].sum_q;
   assign cout      = stg[NSEG-1].cy_q;
   assign ovf       = stg[NSEG-1].last.ovf_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe (WIDTH=32, SEG=8): directed and random adds through a result scoreboard.
module tb_adder_pipe;
   localparam int W = 32;
   localparam int S = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
`ifdef ADD_SUB_EN
   logic         sub = 1'b0;
`endif

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [33:0] sb_q[$];

   adder_pipe #(.WIDTH(W), .SEG(S)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef ADD_SUB_EN
      .sub       (sub),
`endif
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result packed as {cout, ovf, sum}.
   function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic c, input logic sb);
      logic [32:0] t;
      logic [31:0] yy;
      logic        cc;
      logic        v;
      yy = sb ? ~y : y;
      cc = sb ? 1'b1 : c;
      t  = {1'b0, x} + {1'b0, yy} + {32'b0, cc};
      v  = (x[31] == yy[31]) && (t[31] != x[31]);
      return {t[32], v, t[31:0]};
   endfunction

   always @(negedge clk) begin
      chk("in_ready_rule", {33'b0, in_ready}, {33'b0, !(out_valid && !out_ready)});
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0)
            chk("spurious_output", {33'b0, out_valid}, 34'b0);
         else
            chk("result", {cout, ovf, sum}, sb_q.pop_front());
      end
   end

   task automatic send(input logic [31:0] ta, input logic [31:0] tb_, input logic tc,
                       input logic [33:0] exp);
      int w;
      a = ta;
      b = tb_;
      cin = tc;
      in_valid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         w++;
         @(negedge clk);
      end
      if (!in_ready)
         chk("accept_timeout", {33'b0, in_ready}, 34'd1);
      else
         sb_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 100) begin
         @(posedge clk);
         w++;
      end
      #1;
      chk("drain", {2'b0, 32'(sb_q.size())}, 34'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      int          lat;

      #1;
      chk("rst_out_valid", {33'b0, out_valid}, 34'd0);
      chk("rst_in_ready", {33'b0, in_ready}, 34'd1);
      chk("rst_result", {cout, ovf, sum}, 34'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      send(32'h0000_0001, 32'h0000_0002, 1'b0, {1'b0, 1'b0, 32'h0000_0003});
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 20);
      chk("latency", {2'b0, 32'(lat)}, 34'd4);
      drain();

      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, {1'b1, 1'b0, 32'h0000_0000});
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, {1'b0, 1'b1, 32'h8000_0000});
      send(32'h8000_0000, 32'h8000_0000, 1'b0, {1'b1, 1'b1, 32'h0000_0000});
      send(32'h00FF_00FF, 32'h0001_0001, 1'b1, {1'b0, 1'b0, 32'h0100_0101});
      drain();

`ifdef ADD_SUB_EN
      sub = 1'b1;
      send(32'd5, 32'd7, 1'b0, {1'b0, 1'b0, 32'hFFFF_FFFE});
      send(32'd7, 32'd5, 1'b1, {1'b1, 1'b0, 32'h0000_0002});
      send(32'h8000_0000, 32'd1, 1'b0, {1'b1, 1'b1, 32'h7FFF_FFFF});
      sub = 1'b0;
      drain();
`endif

      fork
         for (int i = 0; i < 16; i++) begin
            ra = $urandom;
            rb = $urandom;
            rc = 1'($urandom_range(0, 1));
            send(ra, rb, rc, model(ra, rb, rc, 1'b0));
         end
         begin
            repeat (8) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      out_ready = 1'b0;
      for (int i = 0; i < 3; i++)
         send(32'(i), 32'h10, 1'b0, model(32'(i), 32'h10, 1'b0, 1'b0));
      @(posedge clk);
      #1;
      chk("pre_rst_out_valid", {33'b0, out_valid}, 34'd1);
      rst = 1'b1;
      sb_q.delete();
      #1;
      chk("mid_rst_out_valid", {33'b0, out_valid}, 34'd0);
      chk("mid_rst_in_ready", {33'b0, in_ready}, 34'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_out_valid", {33'b0, out_valid}, 34'd0);

      send(32'h1234_5678, 32'h1111_1111, 1'b0, {1'b0, 1'b0, 32'h2345_6789});
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
